// File: rtl/rvv_insn_queue.sv
// Vector instruction issue queue: filters non-vector opcodes and buffers legal ones in a FWFT FIFO.
// Zero-bubble: a push into an empty queue is visible the next cycle; host_ready depends on registered state and flush only.
module rvv_insn_queue #(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  host_valid,
  input  logic [INSN_WIDTH-1:0] host_insn,
  output logic                  host_ready,
  output logic                  insn_valid,
  output logic [INSN_WIDTH-1:0] insn_out,
  input  logic                  insn_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  illegal,
  output logic [15:0]           illegal_cnt
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_OP_V     = 7'h57;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;

  logic [INSN_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_illegal;
  logic [15:0]           r_illegal_cnt;

  logic [6:0]            w_opcode;
  logic [2:0]            w_width;
  logic                  w_vec_width;
  logic                  w_legal;
  logic                  w_push;
  logic                  w_push_legal;
  logic                  w_push_illegal;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_nxt;

  assign w_opcode = host_insn[6:0];
  assign w_width  = host_insn[14:12];

  // Vector loads/stores reuse the FP opcodes; only widths 0,5,6,7 encode vector element sizes.
  assign w_vec_width = (w_width == 3'd0) || (w_width == 3'd5) ||
                       (w_width == 3'd6) || (w_width == 3'd7);

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP_V:                  w_legal = 1'b1;
      OPC_LOAD_FP, OPC_STORE_FP: w_legal = w_vec_width;
      default:                   w_legal = 1'b0;
    endcase
  end

  assign host_ready     = rst && (r_count != FULL_CNT) && !flush;
  assign insn_valid     = (r_count != '0);
  assign insn_out       = insn_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push         = host_valid && host_ready;
  assign w_push_legal   = w_push && w_legal;
  assign w_push_illegal = w_push && !w_legal;
  assign w_pop          = insn_valid && insn_ready && !flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_legal, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_legal) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Storage is left unreset: count gates insn_out, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push_legal) r_mem[r_wr_ptr] <= host_insn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_illegal <= w_push_illegal;
      if (w_push_illegal && (r_illegal_cnt != 16'hFFFF)) begin
        r_illegal_cnt <= r_illegal_cnt + 16'd1;
      end
    end
  end

  assign count       = r_count;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_illegal_cnt;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) r_count <= FULL_CNT);
  a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(r_wr_ptr - r_rd_ptr) == r_count[PTR_W-1:0]);

endmodule

// File: tb/tb_rvv_insn_queue.sv
// Directed bench for rvv_insn_queue: vector table for single-cycle behaviour plus hand sequences for fill, flush and reset.
module tb_rvv_insn_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        host_valid;
  logic [31:0] host_insn;
  logic        host_ready;
  logic        insn_valid;
  logic [31:0] insn_out;
  logic        insn_ready;
  logic [3:0]  count;
  logic        illegal;
  logic [15:0] illegal_cnt;

  int errors = 0;
  int checks = 0;

  rvv_insn_queue #(.INSN_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .host_valid(host_valid), .host_insn(host_insn), .host_ready(host_ready),
    .insn_valid(insn_valid), .insn_out(insn_out), .insn_ready(insn_ready),
    .count(count), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fl;
    logic        hv;
    logic [31:0] insn;
    logic        ir;
    logic        hr;
    logic        iv;
    logic [31:0] out;
    logic [3:0]  cnt;
    logic        ill;
    logic [15:0] icnt;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic fl, input logic hv, input logic [31:0] insn, input logic ir);
    @(negedge clk);
    flush      = fl;
    host_valid = hv;
    host_insn  = insn;
    insn_ready = ir;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill_insn [9];
  logic [31:0] c [4];
  int          pop_idx;
  logic        will_push;

  initial begin
    //            fl   hv   insn          ir   hr   iv   out           cnt  ill  icnt
    vecs[0]  = '{1'b0,1'b0,32'h00000000,1'b0,1'b1,1'b0,32'h00000000,4'd0,1'b0,16'd0};
    vecs[1]  = '{1'b0,1'b1,32'h02208057,1'b0,1'b1,1'b1,32'h02208057,4'd1,1'b0,16'd0};
    vecs[2]  = '{1'b0,1'b0,32'h00000000,1'b1,1'b1,1'b0,32'h00000000,4'd0,1'b0,16'd0};
    vecs[3]  = '{1'b0,1'b1,32'h00000013,1'b0,1'b1,1'b0,32'h00000000,4'd0,1'b1,16'd1};
    vecs[4]  = '{1'b0,1'b1,32'h00007007,1'b0,1'b1,1'b1,32'h00007007,4'd1,1'b0,16'd1};
    vecs[5]  = '{1'b0,1'b1,32'h00002007,1'b1,1'b1,1'b0,32'h00000000,4'd0,1'b1,16'd2};
    vecs[6]  = '{1'b0,1'b1,32'h00005027,1'b0,1'b1,1'b1,32'h00005027,4'd1,1'b0,16'd2};
    vecs[7]  = '{1'b0,1'b1,32'h12345057,1'b1,1'b1,1'b1,32'h12345057,4'd1,1'b0,16'd2};
    vecs[8]  = '{1'b0,1'b0,32'h00000000,1'b1,1'b1,1'b0,32'h00000000,4'd0,1'b0,16'd2};
    vecs[9]  = '{1'b0,1'b0,32'h00000000,1'b1,1'b1,1'b0,32'h00000000,4'd0,1'b0,16'd2};
    vecs[10] = '{1'b0,1'b1,32'h00004007,1'b0,1'b1,1'b0,32'h00000000,4'd0,1'b1,16'd3};
    vecs[11] = '{1'b0,1'b1,32'h0000006F,1'b0,1'b1,1'b0,32'h00000000,4'd0,1'b1,16'd4};
    vecs[12] = '{1'b0,1'b0,32'h00000000,1'b0,1'b1,1'b0,32'h00000000,4'd0,1'b0,16'd4};

    for (int k = 0; k < 9; k++) fill_insn[k] = 32'hA0000057 + (32'(k) << 16);
    for (int k = 0; k < 4; k++) c[k] = 32'hC0000057 + (32'(k) << 20);

    rst = 1'b0; flush = 1'b0; host_valid = 1'b0; host_insn = '0; insn_ready = 1'b0;
    #10;
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    chk("rst_insn_valid", 32'(insn_valid), 32'd0);
    chk("rst_insn_out", insn_out, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    #10;
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].fl, vecs[i].hv, vecs[i].insn, vecs[i].ir);
      chk($sformatf("v%0d_host_ready", i), 32'(host_ready), 32'(vecs[i].hr));
      chk($sformatf("v%0d_insn_valid", i), 32'(insn_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_insn_out", i), insn_out, vecs[i].out);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_illegal_cnt", i), 32'(illegal_cnt), 32'(vecs[i].icnt));
    end

    // Fill to DEPTH, hold the ninth, then stream everything out through the wrap.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, fill_insn[k], 1'b0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_host_ready", 32'(host_ready), 32'd0);
    step(1'b0, 1'b1, fill_insn[8], 1'b0);
    step(1'b0, 1'b1, fill_insn[8], 1'b0);
    chk("full_hold_count", 32'(count), 32'd8);
    chk("full_hold_out", insn_out, fill_insn[0]);

    pop_idx = 0;
    for (int cyc = 0; cyc < 20 && pop_idx < 9; cyc++) begin
      @(negedge clk);
      insn_ready = 1'b1;
      chk($sformatf("stream_valid_%0d", pop_idx), 32'(insn_valid), 32'd1);
      if (insn_valid) begin
        chk($sformatf("stream_order_%0d", pop_idx), insn_out, fill_insn[pop_idx]);
        pop_idx++;
      end
      will_push = host_valid && host_ready;
      @(posedge clk);
      #1;
      if (will_push) host_valid = 1'b0;
    end
    chk("stream_pop_total", 32'(pop_idx), 32'd9);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_end_out", insn_out, 32'd0);

    // Simultaneous legal push and pop at count 3.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, c[k], 1'b0);
    chk("pp_pre_count", 32'(count), 32'd3);
    step(1'b0, 1'b1, c[3], 1'b1);
    chk("pp_count", 32'(count), 32'd3);
    chk("pp_head", insn_out, c[1]);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pp_drain1", insn_out, c[2]);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pp_drain2", insn_out, c[3]);
    chk("pp_drain2_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pp_drain3_count", 32'(count), 32'd0);

    // Flush at count 5 with a push and a pop both requested.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, fill_insn[k], 1'b0);
    chk("fl_pre_count", 32'(count), 32'd5);
    @(negedge clk);
    flush = 1'b1; host_valid = 1'b1; host_insn = 32'h02208057; insn_ready = 1'b1;
    #1;
    chk("fl_host_ready", 32'(host_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_insn_valid", 32'(insn_valid), 32'd0);
    chk("fl_insn_out", insn_out, 32'd0);
    chk("fl_illegal_cnt", 32'(illegal_cnt), 32'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("fl_after_host_ready", 32'(host_ready), 32'd1);
    chk("fl_after_count", 32'(count), 32'd0);

    // Refill to 4, then drop reset between clock edges.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, c[k], 1'b0);
    host_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_insn_valid", 32'(insn_valid), 32'd0);
    chk("ar_insn_out", insn_out, 32'd0);
    chk("ar_host_ready", 32'(host_ready), 32'd0);
    chk("ar_illegal_cnt", 32'(illegal_cnt), 32'd0);
    #20;
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ar_after_host_ready", 32'(host_ready), 32'd1);
    chk("ar_after_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
